// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: loads a word over valid/ready and shifts it out
// one bit per shift_en edge. Optional even-parity trailer bit under `PISO_PARITY_EN.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done,
    output logic [0:0]       o_dbg_state
);

`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift_reg;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_serial_out;
    logic             r_serial_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_last;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_next_bit;

    // Bit sitting at the output end of a word for the configured bit order.
    function automatic logic out_bit(input logic [WIDTH-1:0] word);
        return LSB_FIRST ? word[0] : word[WIDTH-1];
    endfunction

    assign load_ready   = (r_state == IDLE);
    assign w_load       = load_valid && load_ready;
    assign w_last       = (r_bit_cnt == '0);
    assign w_shift_next = LSB_FIRST ? (r_shift_reg >> 1) : (r_shift_reg << 1);

`ifdef PISO_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^load_data;
        end
    end

    // Once the last data bit leaves, the parity bit takes the final slot.
    assign w_next_bit = (r_bit_cnt == CW'(1)) ? r_parity : out_bit(w_shift_next);
`else
    assign w_next_bit = out_bit(w_shift_next);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_shift_reg    <= '0;
            r_bit_cnt      <= '0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                // shift_en is ignored here, so a same-edge load only loads.
                if (w_load) begin
                    r_state        <= SHIFT;
                    r_shift_reg    <= load_data;
                    r_bit_cnt      <= LAST_IDX;
                    r_serial_out   <= out_bit(load_data);
                    r_serial_valid <= 1'b1;
                    r_busy         <= 1'b1;
                end
            end else if (shift_en) begin
                if (w_last) begin
                    r_state        <= IDLE;
                    r_serial_out   <= 1'b0;
                    r_serial_valid <= 1'b0;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b1;
                end else begin
                    r_shift_reg  <= w_shift_next;
                    r_bit_cnt    <= r_bit_cnt - CW'(1);
                    r_serial_out <= w_next_bit;
                end
            end
        end
    end

    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in, serial-out transmitter. It is the transmit end for the sipo block.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per enabled clock, MSB-first by default.
- Flags end of frame with a done pulse.
- Shares the clk, rst_n and shift_en conventions of sipo, so one shift_en can drive both ends of a serial link.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB transmitted first

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  block can accept a word (combinational from state)
load_data  input  WIDTH  parallel word to transmit
shift_en  input  1  advance to next bit on this clock edge
serial_out  output  1  current serial bit (registered)
serial_valid  output  1  serial_out holds a frame bit (registered)
busy  output  1  frame in progress
done  output  1  one-cycle pulse after last bit is consumed

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low (rst_n), applied to all flops.
- Reset values: state=IDLE, shift_reg=0, bit_cnt=0, serial_out=0, serial_valid=0, busy=0, done=0. load_ready=1 whenever state=IDLE, including during reset.
- FSM states: IDLE, SHIFT.
- IDLE:
  - load_ready=1, serial_out=0, serial_valid=0, busy=0.
  - On load_valid && load_ready: capture load_data into shift_reg, set bit_cnt=NBITS-1, move to SHIFT.
  - NBITS = WIDTH, or WIDTH+1 with parity enabled.
  - The first bit appears on serial_out in the cycle after the handshake (1-cycle load latency).
- SHIFT:
  - load_ready=0, busy=1, serial_valid=1.
  - serial_out = shift_reg[WIDTH-1] when LSB_FIRST=0, shift_reg[0] when LSB_FIRST=1.
- Advance: at each posedge with shift_en=1 in SHIFT:
  - If bit_cnt>0: shift shift_reg toward the output end, fill with 0, decrement bit_cnt.
  - If bit_cnt==0: go to IDLE, assert done for exactly 1 cycle, clear serial_valid and serial_out.
- Stall: shift_en=0 in SHIFT holds serial_out, bit_cnt and state unchanged for any number of cycles.
- Receiver timing: serial_out changes only on the edge where a shift_en-gated receiver samples it. A sipo sharing shift_en therefore captures bit k on the same edge that piso_tx advances to bit k+1.
- Frame length: exactly NBITS enabled edges from first bit to done.
- Load while busy: load_valid during SHIFT is ignored (load_ready=0). Upstream must hold load_valid until load_ready. No data loss, no queuing.
- load_data is sampled only on the handshake edge. Changes afterward do not affect the frame in flight.
- shift_en in IDLE has no effect.
- Load and shift_en on the same edge in IDLE: only the load takes effect.
- Back-to-back frames: next load accepted in the cycle done is high (state=IDLE). Minimum gap is 1 idle cycle.
- Reset mid-frame: asynchronously abort to IDLE with reset values. The partial frame is discarded and no done is issued.
- done, busy, serial_valid are mutually consistent: done and busy are never both 1.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - Even-parity bit = XOR of all WIDTH captured data bits, computed at load and held in a separate register.
  - Sent as bit NBITS-1 after the last data bit. NBITS=WIDTH+1.
  - bit_cnt widened to cover WIDTH+1.
- Undefined:
  - No parity logic. NBITS=WIDTH.
  - Frame ends after the last data bit.

Test Plan:
1. Reset, load 8'hAC, shift_en=1 continuously -> serial_out sequence 1,0,1,0,1,1,0,0 on consecutive cycles; serial_valid high 8 cycles; done pulses once on the cycle after bit 8; load_ready returns to 1.
2. Loopback piso_tx -> sipo with shared shift_en, load 8'h5A -> sipo parallel_out = 8'h5A when done pulses.
3. Load 8'hAC, toggle shift_en 1/0 each cycle -> each bit held 2 cycles; done after 8 enabled edges (~16 cycles); no bit skipped or repeated.
4. Load 8'hAC, then assert load_valid with 8'hFF during SHIFT -> ignored, stream still 8'hAC; 8'hFF accepted only once load_ready=1 and then transmitted fully.
5. Deassert rst_n after 3 bits of 8'hF0 -> serial_out=0, serial_valid=0, busy=0, done=0 immediately; no done pulse; next load of 8'h0F transmits cleanly.
6. LSB_FIRST=1, load 8'hAC -> sequence 0,0,1,1,0,1,0,1. With PISO_PARITY_EN: 8'hAC -> 9th bit 0; 8'h01 -> 9th bit 1; done after 9 enabled edges.
